// File: rtl/seq_slice_adder.sv
// seq_slice_adder: multi-cycle add/sub engine, SLICE bits per RUN cycle, 4-phase req/ack completion.
// Optional early completion once the remaining carry chain is resolved: define SEQ_SLICE_ADDER_EARLY_FIN_EN.
module seq_slice_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic                              sub,
  input  logic                              cin,
  input  logic [WIDTH-1:0]                  x,
  input  logic [WIDTH-1:0]                  y,
  output logic                              ack,
  output logic [WIDTH-1:0]                  s,
  output logic                              cout,
  output logic                              ovf,
  output logic [$clog2(WIDTH/SLICE):0]      cycles
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_xa;
  logic [WIDTH-1:0]  r_yb;
  logic              r_c;
  logic [KW-1:0]     r_k;
  logic              r_ack;
  logic [WIDTH-1:0]  r_s;
  logic              r_cout;
  logic              r_ovf;
  logic [CW-1:0]     r_cycles;

  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_xa_nxt;
  logic [WIDTH-1:0]  w_yb_nxt;
  logic              w_c_nxt;
  logic [KW-1:0]     w_k_nxt;
  logic              w_ack_nxt;
  logic [WIDTH-1:0]  w_s_nxt;
  logic              w_cout_nxt;
  logic              w_ovf_nxt;
  logic [CW-1:0]     w_cycles_nxt;

  int unsigned       w_base;
  logic [SLICE-1:0]  w_xs;
  logic [SLICE-1:0]  w_ys;
  logic [SLICE-1:0]  w_sum;
  logic              w_carry;
  logic              w_cmsb;
  logic              w_last;

  // Bitwise ripple through the current slice; w_cmsb ends as the carry into the slice's top bit.
  always_comb begin
    w_base  = 32'(r_k) * SLICE;
    w_xs    = r_xa[w_base +: SLICE];
    w_ys    = r_yb[w_base +: SLICE];
    w_sum   = '0;
    w_carry = r_c;
    w_cmsb  = r_c;
    for (int unsigned i = 0; i < SLICE; i++) begin
      w_sum[i] = w_xs[i] ^ w_ys[i] ^ w_carry;
      w_cmsb   = w_carry;
      w_carry  = (w_xs[i] & w_ys[i]) | (w_carry & (w_xs[i] ^ w_ys[i]));
    end
    w_last = (r_k == KW'(N - 1));
  end

`ifdef SEQ_SLICE_ADDER_EARLY_FIN_EN
  logic [WIDTH-1:0]  w_upper_mask;
  logic              w_upper_gen;

  // No carry can be generated above the current slice and none is entering: upper sum is xa^yb.
  always_comb begin
    w_upper_mask = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      w_upper_mask[b] = (b >= (w_base + SLICE));
    end
    w_upper_gen = |(r_xa & r_yb & w_upper_mask);
  end
`endif

  // Next-state and output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_xa_nxt     = r_xa;
    w_yb_nxt     = r_yb;
    w_c_nxt      = r_c;
    w_k_nxt      = r_k;
    w_ack_nxt    = r_ack;
    w_s_nxt      = r_s;
    w_cout_nxt   = r_cout;
    w_ovf_nxt    = r_ovf;
    w_cycles_nxt = r_cycles;

    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_xa_nxt     = x;
          w_yb_nxt     = sub ? ~y : y;
          w_c_nxt      = sub ? 1'b1 : cin;
          w_k_nxt      = '0;
          w_cycles_nxt = '0;
          w_state_nxt  = ST_RUN;
        end
      end

      ST_RUN: begin
        w_s_nxt[w_base +: SLICE] = w_sum;
        w_c_nxt      = w_carry;
        w_cycles_nxt = r_cycles + CW'(1);
        if (w_last) begin
          w_cout_nxt  = w_carry;
          w_ovf_nxt   = w_cmsb ^ w_carry;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_k_nxt = r_k + KW'(1);
`ifdef SEQ_SLICE_ADDER_EARLY_FIN_EN
          if (!w_carry && !w_upper_gen) begin
            w_s_nxt     = (w_s_nxt & ~w_upper_mask) | ((r_xa ^ r_yb) & w_upper_mask);
            w_cout_nxt  = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end
`endif
        end
      end

      ST_DONE: begin
        if (!req) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_xa     <= '0;
      r_yb     <= '0;
      r_c      <= 1'b0;
      r_k      <= '0;
      r_ack    <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_xa     <= w_xa_nxt;
      r_yb     <= w_yb_nxt;
      r_c      <= w_c_nxt;
      r_k      <= w_k_nxt;
      r_ack    <= w_ack_nxt;
      r_s      <= w_s_nxt;
      r_cout   <= w_cout_nxt;
      r_ovf    <= w_ovf_nxt;
      r_cycles <= w_cycles_nxt;
    end
  end

  assign ack    = r_ack;
  assign s      = r_s;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign cycles = r_cycles;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Scoreboard bench for seq_slice_adder (WIDTH=32, SLICE=4); expected cycles follow SEQ_SLICE_ADDER_EARLY_FIN_EN.
module tb_seq_slice_adder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        sub;
  logic        cin;
  logic [31:0] x;
  logic [31:0] y;
  logic        ack;
  logic [31:0] s;
  logic        cout;
  logic        ovf;
  logic [3:0]  cycles;

  typedef struct {
    string       name;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          cyc;
    int          cap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;
  int   edge_cnt;

  seq_slice_adder #(.WIDTH(32), .SLICE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .sub    (sub),
    .cin    (cin),
    .x      (x),
    .y      (y),
    .ack    (ack),
    .s      (s),
    .cout   (cout),
    .ovf    (ovf),
    .cycles (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int exp_cyc(input int early);
`ifdef SEQ_SLICE_ADDER_EARLY_FIN_EN
    return early;
`else
    if (early > 0) return 8;
    return 8;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: on every ack rising edge, pop the oldest expectation and compare.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack && !prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_ack: ack=1 at edge %0d, expected no ack", edge_cnt);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_s"},       64'(s),      64'(e.s));
          check({e.name, "_cout"},    64'(cout),   64'(e.cout));
          check({e.name, "_ovf"},     64'(ovf),    64'(e.ovf));
          check({e.name, "_cycles"},  64'(cycles), 64'(e.cyc));
          check({e.name, "_latency"}, 64'(edge_cnt - e.cap), 64'(e.cyc));
        end
      end
      prev = ack;
    end
  end

  task automatic do_op(input string name, input logic [31:0] ax, input logic [31:0] ay,
                       input logic asub, input logic acin, input logic [31:0] es,
                       input logic ec, input logic eo, input int early_cyc,
                       input int hold, input bit inline_start);
    exp_t e;
    int   waited;
    if (!inline_start) @(negedge clk);
    x   = ax;
    y   = ay;
    sub = asub;
    cin = acin;
    req = 1'b1;
    e.name = name;
    e.s    = es;
    e.cout = ec;
    e.ovf  = eo;
    e.cyc  = exp_cyc(early_cyc);
    e.cap  = edge_cnt + 1;
    sb_q.push_back(e);
    waited = 0;
    while (!ack && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: ack=0 after %0d cycles, expected ack=1", name, waited);
    end
    repeat (hold) begin
      @(negedge clk);
      check({name, "_hold_ack"}, 64'(ack), 64'(1));
      check({name, "_hold_s"},   64'(s),   64'(es));
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_ack_fall"}, 64'(ack), 64'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = 1'b0;
    sub = 1'b0;
    cin = 1'b0;
    x   = '0;
    y   = '0;
    repeat (2) @(negedge clk);
    check("rst_ack",    64'(ack),    64'(0));
    check("rst_s",      64'(s),      64'(0));
    check("rst_cout",   64'(cout),   64'(0));
    check("rst_ovf",    64'(ovf),    64'(0));
    check("rst_cycles", 64'(cycles), 64'(0));
    rst = 1'b0;

    do_op("add_f_1",     32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0, 2, 3, 1'b0);
    do_op("add_ff_1",    32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 3, 0, 1'b0);
    do_op("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 8, 0, 1'b0);
    do_op("add_zero",    32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1, 0, 1'b1);
    do_op("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 8, 0, 1'b0);
    do_op("sub_5_7",     32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1, 0, 1'b0);
    do_op("sub_7_5",     32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 8, 0, 1'b0);
    do_op("add_cin",     32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 8, 0, 1'b0);
    do_op("sub_min_1",   32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 8, 0, 1'b0);

    // Abort an operation once slice 3 is current; it must leave no ack behind.
    @(negedge clk);
    x   = 32'h7FFFFFFF;
    y   = 32'h00000001;
    sub = 1'b0;
    cin = 1'b0;
    req = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ack",    64'(ack),    64'(0));
    check("abort_s",      64'(s),      64'(0));
    check("abort_cout",   64'(cout),   64'(0));
    check("abort_ovf",    64'(ovf),    64'(0));
    check("abort_cycles", 64'(cycles), 64'(0));
    req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_hold_s", 64'(s), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", 64'(ack), 64'(0));
    end

    do_op("post_rst",    32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 5, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_slice_adder.md
Name: seq_slice_adder

Overview:
- Parametrised, clocked successor to the single-bit full-adder cell with completion signalling.
- Adds or subtracts two WIDTH-bit operands, SLICE bits per clock, as a ripple across slices.
- Signals completion through a 4-phase req/ack handshake and can finish early once the remaining carry chain is resolved.
- Sits under the math block as the shared multi-cycle add/sub engine.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per RUN cycle; N = WIDTH/SLICE slices.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  4-phase request; operands must be stable while req=1.
- sub  input  1  0: x+y+cin; 1: x+~y+1 (cin ignored).
- cin  input  1  carry in (add only).
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- ack  output  1  result valid; 4-phase acknowledge.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- cycles  output  $clog2(N)+1  RUN cycles used by the last operation.

Behaviour:
- Reset (async): state=IDLE; ack=0, s=0, cout=0, ovf=0, cycles=0; internal operand, carry and slice-index registers cleared.
- Reset during any state aborts the operation; no ack is produced for the aborted request.
- IDLE: on an edge with req=1, latch xa=x, yb=(sub ? ~y : y), c=(sub ? 1 : cin); set k=0, cycles=0; go RUN. req=0 keeps IDLE.
- RUN: each edge processes slice k with bitwise ripple:
  - s[k*SLICE +: SLICE] = xa^yb^carries, c = slice carry-out, cycles++.
  - If k==N-1: cout=c, ovf=carry-into-MSB^c; go DONE, ack=1 (registered, same edge).
  - Otherwise k++.
- Early completion (EARLY_FIN_EN only): evaluated at the end of each RUN edge that is not the last slice.
  - Condition: new c==0 and (xa&yb)==0 for every bit above the current slice.
  - Action: fill all upper s bits with xa^yb; cout=0, ovf=0; go DONE, ack=1 on that same edge.
- Latency: req sampled at edge E0; ack high after edge E0+N without early exit, minimum E0+1 with it.
- DONE: ack, s, cout, ovf, cycles held stable while req=1. On an edge with req=0: ack=0, go IDLE. s/cout/ovf/cycles keep their values until the next capture.
- A new req is accepted only from IDLE. req must be low for at least one edge between operations.
- req dropping during RUN is a protocol violation: computation still completes, ack pulses for one cycle in DONE, then returns to IDLE.
- Wrap-around: results are modulo 2^WIDTH; the carry is reported only on cout.

Optional Feature:
- Macro SEQ_SLICE_ADDER_EARLY_FIN_EN.
- Defined: early-completion detection as described above; cycles ranges 1..N.
- Undefined: every operation takes exactly N RUN cycles; cycles always equals N; results are identical to the defined case.

Test Plan (WIDTH=32, SLICE=4, N=8):
1. x=0x0000000F, y=0x00000001, cin=0, sub=0 -> s=0x00000010, cout=0, ovf=0; cycles=2 with EARLY_FIN_EN, 8 without; ack exactly cycles edges after capture.
2. x=0xFFFFFFFF, y=0x00000001, cin=0 -> s=0x00000000, cout=1, ovf=0, cycles=8 in both builds. Also x=0, y=0, cin=0 -> s=0, cycles=1 (early build).
3. x=0x7FFFFFFF, y=0x00000001, cin=0 -> s=0x80000000, cout=0, ovf=1, cycles=8.
4. sub=1, x=5, y=7 -> s=0xFFFFFFFE, cout=0, ovf=0. sub=1, x=7, y=5 -> s=0x00000002, cout=1.
5. Handshake: hold req 3 edges after ack -> ack, s stable; drop req -> ack=0 after next edge. Re-raise req in the same cycle ack falls -> captured only on the following edge from IDLE.
6. Assert rst asynchronously mid-RUN (k=3) -> ack/s/cout/ovf/cycles=0 immediately. After release, a fresh request completes correctly; no stray ack from the aborted operation.
